alpha_converge: RTL and testbench

- Downstream neighbour of the per-point action-selection stage.
- Consumes each iteration's winning alpha vectors and actions, and commits them to the persistent alpha set and policy registers that feed the next backup iteration.
- Computes the Bellman residual, max |alpha_new − alpha_old|, serially over belief points.
- Decides between two outcomes: launch another PBVI iteration (pulse `en_next`), or stop as converged or timed out.

---
 rtl/pbvi_pkg.sv | 18 +
 rtl/alpha_absdiff_max.sv | 26 ++
 rtl/alpha_converge.sv | 206 ++++++++++++++++++++
 tb/tb_alpha_converge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pbvi_pkg.sv
// Shared PBVI constants and types for the alpha-vector pipeline stages.
package pbvi_pkg;

  localparam int unsigned N_POINT  = 16;
  localparam int unsigned N_STATE  = 2;
  localparam int unsigned N_ACTION = 3;
  localparam int unsigned VAL_W    = 16;

  typedef logic [1:0] action_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DECIDE,
    DONE
  } conv_state_t;

endpackage

// File: rtl/alpha_absdiff_max.sv
// Per-point combinational unit: folds |new - old| of every state into a running maximum.
module alpha_absdiff_max #(
  parameter int unsigned N_STATE = 2,
  parameter int unsigned VAL_W   = 16
) (
  input  logic [N_STATE-1:0][VAL_W-1:0] new_vec,
  input  logic [N_STATE-1:0][VAL_W-1:0] old_vec,
  input  logic [VAL_W-1:0]              max_in,
  output logic [VAL_W-1:0]              max_out
);

  logic [VAL_W-1:0] diff;

  always_comb begin
    max_out = max_in;
    diff    = '0;
    for (int s = 0; s < N_STATE; s++) begin
      // Larger minus smaller keeps the difference unsigned without wrap.
      diff = (new_vec[s] >= old_vec[s]) ? (new_vec[s] - old_vec[s]) : (old_vec[s] - new_vec[s]);
      if (diff > max_out) begin
        max_out = diff;
      end
    end
  end

endmodule

// File: rtl/alpha_converge.sv
// Commits each iteration's alpha set / policy, measures the Bellman residual serially and
// decides between another PBVI iteration and stopping. Optional macro: POLICY_STABLE_EN.
module alpha_converge #(
  parameter int unsigned N_POINT  = pbvi_pkg::N_POINT,
  parameter int unsigned N_STATE  = pbvi_pkg::N_STATE,
  parameter int unsigned VAL_W    = pbvi_pkg::VAL_W,
  parameter int unsigned EPS      = 4,
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned IW       = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      en_loop,
  input  logic                                      clear,
  input  logic [N_POINT-1:0][N_STATE-1:0][VAL_W-1:0] alpha_in,
  input  logic [N_POINT-1:0][1:0]                   action_in,
  output logic [N_POINT-1:0][N_STATE-1:0][VAL_W-1:0] alpha_set,
  output logic [N_POINT-1:0][1:0]                   policy,
  output logic [VAL_W-1:0]                          residual,
  output logic [IW-1:0]                             iter_count,
  output logic                                      en_next,
  output logic                                      busy,
  output logic                                      converged,
  output logic                                      timeout,
  output logic                                      overrun
`ifdef POLICY_STABLE_EN
  ,
  output logic                                      policy_changed
`endif
);

  import pbvi_pkg::*;

  localparam int unsigned IdxW = (N_POINT > 1) ? $clog2(N_POINT) : 1;

  conv_state_t state_q, state_d;

  logic [IdxW-1:0]                          idx_q;
  logic [VAL_W-1:0]                         run_max_q;
  logic [VAL_W-1:0]                         max_upd;
  logic [N_POINT-1:0][N_STATE-1:0][VAL_W-1:0] shadow_q;
  logic [N_POINT-1:0][N_STATE-1:0][VAL_W-1:0] alpha_set_q;
  action_t [N_POINT-1:0]                    shadow_act_q;
  action_t [N_POINT-1:0]                    policy_q;
  logic [VAL_W-1:0]                         residual_q;
  logic [IW-1:0]                            iter_q;
  logic [IW-1:0]                            iter_next;
  logic                                     en_loop_q;
  logic                                     en_next_q;
  logic                                     converged_q;
  logic                                     timeout_q;
  logic                                     overrun_q;
  logic                                     start;
  logic                                     res_ok;
  logic                                     cap_hit;
  logic                                     conv_ok;

  alpha_absdiff_max #(
    .N_STATE (N_STATE),
    .VAL_W   (VAL_W)
  ) u_absdiff (
    .new_vec (shadow_q[idx_q]),
    .old_vec (alpha_set_q[idx_q]),
    .max_in  (run_max_q),
    .max_out (max_upd)
  );

  assign start     = en_loop & ~en_loop_q;
  assign iter_next = (iter_q == {IW{1'b1}}) ? iter_q : iter_q + 1'b1;
  assign cap_hit   = (32'(iter_q) + 32'd1) >= MAX_ITER;
  assign res_ok    = 32'(run_max_q) <= EPS;

`ifdef POLICY_STABLE_EN
  logic act_diff_q;
  logic policy_changed_q;

  assign conv_ok        = res_ok & ~act_diff_q;
  assign policy_changed = policy_changed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_diff_q       <= 1'b0;
      policy_changed_q <= 1'b0;
    end else if (clear) begin
      act_diff_q       <= 1'b0;
      policy_changed_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        act_diff_q <= 1'b0;
      end else if (state_q == COMPARE) begin
        act_diff_q <= act_diff_q | (shadow_act_q[idx_q] != policy_q[idx_q]);
      end else if (state_q == DECIDE) begin
        policy_changed_q <= act_diff_q;
      end
    end
  end
`else
  assign conv_ok = res_ok;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = COMPARE;
        COMPARE: if (idx_q == IdxW'(N_POINT - 1)) state_d = DECIDE;
        DECIDE:  state_d = (conv_ok || cap_hit) ? DONE : IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q == COMPARE) || (state_q == DECIDE);
    alpha_set  = alpha_set_q;
    policy     = policy_q;
    residual   = residual_q;
    iter_count = iter_q;
    en_next    = en_next_q;
    converged  = converged_q;
    timeout    = timeout_q;
    overrun    = overrun_q;
  end

  // Datapath and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_loop_q    <= 1'b0;
      idx_q        <= '0;
      run_max_q    <= '0;
      shadow_q     <= '0;
      shadow_act_q <= '0;
      alpha_set_q  <= '0;
      policy_q     <= '0;
      residual_q   <= '0;
      iter_q       <= '0;
      en_next_q    <= 1'b0;
      converged_q  <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (clear) begin
      en_loop_q    <= 1'b0;
      idx_q        <= '0;
      run_max_q    <= '0;
      shadow_q     <= '0;
      shadow_act_q <= '0;
      alpha_set_q  <= '0;
      policy_q     <= '0;
      residual_q   <= '0;
      iter_q       <= '0;
      en_next_q    <= 1'b0;
      converged_q  <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      en_loop_q <= en_loop;
      en_next_q <= 1'b0;
      if (start && busy) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            shadow_q     <= alpha_in;
            shadow_act_q <= action_in;
            idx_q        <= '0;
            run_max_q    <= '0;
          end
        end
        COMPARE: begin
          run_max_q <= max_upd;
          idx_q     <= idx_q + 1'b1;
        end
        DECIDE: begin
          alpha_set_q <= shadow_q;
          policy_q    <= shadow_act_q;
          residual_q  <= run_max_q;
          iter_q      <= iter_next;
          if (conv_ok) begin
            converged_q <= 1'b1;
          end else if (cap_hit) begin
            timeout_q <= 1'b1;
          end else begin
            en_next_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_converge.sv
// Directed self-checking bench for alpha_converge (MAX_ITER overridden to 4).
module tb_alpha_converge;

  localparam int unsigned NP = 16;
  localparam int unsigned NS = 2;
  localparam int unsigned VW = 16;
  localparam int unsigned IW = 8;

  typedef logic [NP-1:0][NS-1:0][VW-1:0] aset_t;
  typedef logic [NP-1:0][1:0]            pol_t;

  logic          clk;
  logic          rst_n;
  logic          en_loop;
  logic          clear;
  aset_t         alpha_in;
  pol_t          action_in;
  aset_t         alpha_set;
  pol_t          policy;
  logic [VW-1:0] residual;
  logic [IW-1:0] iter_count;
  logic          en_next;
  logic          busy;
  logic          converged;
  logic          timeout;
  logic          overrun;
`ifdef POLICY_STABLE_EN
  logic          policy_changed;
`endif

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  alpha_converge #(
    .MAX_ITER (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_loop    (en_loop),
    .clear      (clear),
    .alpha_in   (alpha_in),
    .action_in  (action_in),
    .alpha_set  (alpha_set),
    .policy     (policy),
    .residual   (residual),
    .iter_count (iter_count),
    .en_next    (en_next),
    .busy       (busy),
    .converged  (converged),
    .timeout    (timeout),
    .overrun    (overrun)
`ifdef POLICY_STABLE_EN
    ,
    .policy_changed (policy_changed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (en_next === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic aset_t all_val(input logic [VW-1:0] v);
    aset_t r;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) r[p][s] = v;
    return r;
  endfunction

  function automatic pol_t all_act(input logic [1:0] a);
    pol_t r;
    for (int p = 0; p < NP; p++) r[p] = a;
    return r;
  endfunction

  // Raise en_loop, wait (bounded) for en_next; lat = posedge count from the sampling edge, or -1.
  task automatic launch(output int lat);
    lat = -1;
    @(negedge clk);
    en_loop = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (en_next) begin
        lat = n;
        break;
      end
    end
    @(negedge clk);
    en_loop = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    int    lat;
    int    p0;
    aset_t exp_a;
    pol_t  exp_p;

    rst_n     = 1'b0;
    en_loop   = 1'b0;
    clear     = 1'b0;
    alpha_in  = '0;
    action_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alpha_set", 512'(alpha_set), 512'(0));
    check("rst_iter", 512'(iter_count), 512'(0));
    check("rst_flags", 512'({en_next, busy, converged, timeout, overrun}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // First iteration: everything 100 against the zeroed set
    alpha_in  = all_val(16'd100);
    action_in = all_act(2'b01);
    launch(lat);
    check("first_latency", 512'(lat), 512'(18));
    check("first_residual", 512'(residual), 512'(100));
    check("first_iter", 512'(iter_count), 512'(1));
    check("first_alpha_set", 512'(alpha_set), 512'(all_val(16'd100)));
    check("first_policy", 512'(policy), 512'(all_act(2'b01)));
    check("first_flags", 512'({busy, converged, timeout}), 512'(0));

    // Second iteration converges: residual 3 <= 4
    exp_a = all_val(16'd100);
    exp_a[7][1] = 16'd103;
    alpha_in = exp_a;
    launch(lat);
    check("conv_no_en_next", 512'(lat), 512'(-1));
    check("conv_residual", 512'(residual), 512'(3));
    check("conv_flags", 512'({converged, timeout, busy}), 512'(3'b100));
    check("conv_iter", 512'(iter_count), 512'(2));
    check("conv_alpha_set", 512'(alpha_set), 512'(exp_a));
    alpha_in = all_val(16'd9);
    launch(lat);
    check("done_ignores_edge", 512'(lat), 512'(-1));
    check("done_iter_hold", 512'(iter_count), 512'(2));
    check("done_alpha_hold", 512'(alpha_set), 512'(exp_a));
    check("done_no_overrun", 512'(overrun), 512'(0));

    // Clear, then alternate 50/0 until the iteration cap of 4
    do_clear();
    #1;
    check("clear_alpha_set", 512'(alpha_set), 512'(0));
    check("clear_flags", 512'({converged, iter_count}), 512'(0));
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      alpha_in = (i % 2 == 0) ? all_val(16'd50) : all_val(16'd0);
      launch(lat);
      check("alt_latency", 512'(lat), (i < 3) ? 512'(18) : 512'(-1));
    end
    check("alt_pulses", 512'(pulses - p0), 512'(3));
    check("alt_timeout", 512'({timeout, converged}), 512'(2'b10));
    check("alt_iter", 512'(iter_count), 512'(4));
    check("alt_residual", 512'(residual), 512'(50));

    // Second rising edge 5 cycles into the iteration is an overrun
    do_clear();
    alpha_in = all_val(16'd30);
    p0 = pulses;
    @(negedge clk);
    en_loop = 1'b1;
    repeat (2) @(negedge clk);
    en_loop = 1'b0;
    repeat (3) @(negedge clk);
    en_loop = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (en_next) begin
        lat = n;
        break;
      end
    end
    check("ovr_en_next_seen", 512'(lat > 0), 512'(1));
    check("ovr_flag", 512'(overrun), 512'(1));
    @(negedge clk);
    en_loop = 1'b0;
    repeat (40) @(negedge clk);
    check("ovr_single_commit", 512'(iter_count), 512'(1));
    check("ovr_pulses", 512'(pulses - p0), 512'(1));
    check("ovr_residual", 512'(residual), 512'(30));

    // Asynchronous reset during COMPARE of iteration 2
    do_clear();
    alpha_in  = all_val(16'd100);
    action_in = all_act(2'b01);
    launch(lat);
    check("rst_pre_latency", 512'(lat), 512'(18));
    alpha_in = all_val(16'd200);
    @(negedge clk);
    en_loop = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_busy", 512'(busy), 512'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_alpha", 512'(alpha_set), 512'(0));
    check("rst_mid_outs", 512'({residual, iter_count, policy}), 512'(0));
    check("rst_mid_flags", 512'({en_next, busy, converged, timeout, overrun}), 512'(0));
    @(negedge clk);
    en_loop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    alpha_in = all_val(16'd100);
    launch(lat);
    check("rst_post_latency", 512'(lat), 512'(18));
    check("rst_post_residual", 512'(residual), 512'(100));
    check("rst_post_iter", 512'(iter_count), 512'(1));

    // Identical alphas, point 3 action changes
    exp_p = all_act(2'b01);
    exp_p[3] = 2'b10;
    action_in = exp_p;
    launch(lat);
    check("pol_residual", 512'(residual), 512'(0));
    check("pol_policy", 512'(policy), 512'(exp_p));
`ifdef POLICY_STABLE_EN
    check("pol_latency", 512'(lat), 512'(18));
    check("pol_converged", 512'(converged), 512'(0));
    check("pol_changed", 512'(policy_changed), 512'(1));
`else
    check("pol_latency", 512'(lat), 512'(-1));
    check("pol_converged", 512'(converged), 512'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
